clk_sel_ctrl: RTL and testbench

// - Initiator side of the clock-mux select interface. Runs on an always-on reference clock.
// - Accepts a source-select request and drives sel_o to the clock mux.
// - Waits a settle period, then measures edges of the mux output clock (fed back on mon_clk_i).
// - Reports whether the observed frequency lies in the expected window for the chosen source.

---
 rtl/clk_ctrl_pkg.sv | 14 +
 rtl/clk_edge_counter.sv | 52 +++++
 rtl/clk_sel_ctrl.sv | 155 +++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock-mux select controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } clk_sel_state_e;

    localparam logic CLK_SRC0 = 1'b0;
    localparam logic CLK_SRC1 = 1'b1;

endpackage

// File: rtl/clk_edge_counter.sv
// Counts rising edges of an asynchronous monitor clock in the reference
// clock domain: 2-FF synchronizer, rising-edge detect, saturating counter.
// Edges are only resolved correctly while f(mon_clk_i) < f(clk_i)/2.
module clk_edge_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             mon_clk_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic             meta_q;
    logic             sync_q;
    logic             sync_d;
    logic             rise;
    logic [CNT_W-1:0] cnt_q;

    // Synchronizer plus one history stage; runs in every state so a window
    // never opens on a stale history.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta_q <= mon_clk_i;
            sync_q <= meta_q;
            sync_d <= sync_q;
        end
    end

    assign rise = sync_q & ~sync_d;

    // Saturating edge counter: cleared on request, counts only while enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && rise && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Initiator side of the clock-mux select interface. Drives the mux select,
// waits for the mux to settle, counts feedback-clock edges over a fixed
// window and reports whether the count fits the selected source's range.
module clk_sel_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 256,
    parameter int CNT_W         = 9,
    parameter int MIN0          = 100,
    parameter int MAX0          = 156,
    parameter int MIN1          = 50,
    parameter int MAX1          = 90
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic             req_sel_i,
    output logic             req_ready_o,
    output logic             sel_o,
    input  logic             mon_clk_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ok_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    // One shared cycle counter times both the settle and the measure phase.
    localparam int CYC_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);

    localparam logic [CNT_W-1:0] MIN0_C = CNT_W'(MIN0);
    localparam logic [CNT_W-1:0] MAX0_C = CNT_W'(MAX0);
    localparam logic [CNT_W-1:0] MIN1_C = CNT_W'(MIN1);
    localparam logic [CNT_W-1:0] MAX1_C = CNT_W'(MAX1);

    clk_sel_state_e   state_q;
    clk_sel_state_e   state_d;
    logic [CYC_W-1:0] cyc_q;
    logic             sel_q;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;
    logic             win_ok;
    logic [CNT_W-1:0] res_cnt_q;
    logic             res_ok_q;

    clk_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .mon_clk_i (mon_clk_i),
        .cnt_o     (cnt)
    );

    // FSM state register; a mid-operation reset drops straight to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        accept      = 1'b0;
        cnt_clr     = 1'b1;
        cnt_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                if (cyc_q == WINDOW_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Counter holds its final value for the result load.
                cnt_clr = 1'b0;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase timer: restarts on every state change, advances while busy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_q <= '0;
        end else if (state_d != state_q) begin
            cyc_q <= '0;
        end else if (busy_o) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    // Mux select: only an accepted request can change it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sel_q <= CLK_SRC0;
        end else if (accept) begin
            sel_q <= req_sel_i;
        end
    end

    assign sel_o  = sel_q;
    assign win_ok = (sel_q == CLK_SRC1) ? ((cnt >= MIN1_C) && (cnt <= MAX1_C))
                                        : ((cnt >= MIN0_C) && (cnt <= MAX0_C));

    // Result registers, loaded in DONE and held until the next DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_cnt_q <= '0;
            res_ok_q  <= 1'b0;
        end else if (state_q == DONE) begin
            res_cnt_q <= cnt;
            res_ok_q  <= win_ok;
        end
    end

    // During DONE the fresh result is forwarded so it is valid with done_o.
    assign edge_cnt_o = (state_q == DONE) ? cnt : res_cnt_q;
    assign ok_o       = (state_q == DONE) ? win_ok : res_ok_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl with a short settle/window configuration.
module tb_clk_sel_ctrl;

    localparam int SETTLE = 4;
    localparam int WINDOW = 100;
    localparam int CW     = 9;
    localparam int LAT    = 1 + SETTLE + WINDOW; // accept -> done_o

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_sel_i   = 1'b0;
    logic          mon_clk_i   = 1'b0;
    logic          req_ready_o;
    logic          sel_o;
    logic          busy_o;
    logic          done_o;
    logic          ok_o;
    logic [CW-1:0] edge_cnt_o;

    logic mon_run   = 1'b0;
    logic mon_stuck = 1'b0;

    int checks   = 0;
    int failures = 0;

    clk_sel_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .WINDOW_CYCLES (WINDOW),
        .CNT_W         (CW),
        .MIN0          (20),
        .MAX0          (30),
        .MIN1          (8),
        .MAX1          (12)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_sel_i   (req_sel_i),
        .req_ready_o (req_ready_o),
        .sel_o       (sel_o),
        .mon_clk_i   (mon_clk_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ok_o        (ok_o),
        .edge_cnt_o  (edge_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor clock: 100 ns period while running, otherwise a fixed level.
    always begin
        #50;
        mon_clk_i = mon_run ? ~mon_clk_i : mon_stuck;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done_o !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    // One full request; expects 9..11 edges when want_edges, else exactly 0.
    task automatic run_req(input logic sel, input string tag, input logic exp_ok, input logic want_edges);
        int            n;
        logic [CW-1:0] saved;
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        check({tag, "_ready_at_accept"}, req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        check({tag, "_sel"}, sel_o, sel);
        check({tag, "_busy"}, busy_o, 1);
        check({tag, "_ready_low"}, req_ready_o, 0);
        wait_done(n);
        check({tag, "_latency"}, n + 1, LAT);
        if (want_edges) begin
            check({tag, "_cnt_in_9_11"}, (edge_cnt_o >= 9) && (edge_cnt_o <= 11), 1);
        end else begin
            check({tag, "_cnt_zero"}, edge_cnt_o, 0);
        end
        check({tag, "_ok"}, ok_o, exp_ok);
        saved = edge_cnt_o;
        step();
        check({tag, "_done_pulse_1cyc"}, done_o, 0);
        check({tag, "_cnt_hold"}, edge_cnt_o, saved);
        check({tag, "_ok_hold"}, ok_o, exp_ok);
        check({tag, "_ready_after"}, req_ready_o, 1);
    endtask

    initial begin
        int acc_first;
        int low;
        int second;
        int done_at;
        int sel_moves;
        int n;
        logic seen_done;

        // Reset held for three cycles.
        rst_ni = 1'b0;
        repeat (3) step();
        rst_ni = 1'b1;
        check("rst_sel", sel_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ok", ok_o, 0);
        check("rst_cnt", edge_cnt_o, 0);
        check("rst_ready", req_ready_o, 1);
        check("rst_busy", busy_o, 0);

        mon_run = 1'b1;
        repeat (5) step();

        // clk1 at ~10 edges per window: inside 8..12.
        run_req(1'b1, "sel1", 1'b1, 1'b1);
        // clk0 at ~10 edges per window: below 20.
        run_req(1'b0, "sel0", 1'b0, 1'b1);

        // Held request, same source as already selected.
        req_sel_i   = 1'b0;
        req_valid_i = 1'b1;
        acc_first   = 0;
        low         = 0;
        second      = -1;
        done_at     = -1;
        sel_moves   = 0;
        for (int i = 0; i < 120; i++) begin
            if (req_ready_o === 1'b1) begin
                if (i == 0) acc_first = 1;
                else if (second < 0) second = i;
            end else if (second < 0) begin
                low++;
            end
            if (done_o === 1'b1 && done_at < 0) done_at = i;
            if (sel_o !== 1'b0) sel_moves++;
            step();
        end
        req_valid_i = 1'b0;
        check("hs_first_accept", acc_first, 1);
        check("hs_ready_low_cycles", low, LAT);
        check("hs_done_cycle", done_at, LAT);
        check("hs_second_accept", second, LAT + 1);
        check("hs_sel_stable", sel_moves, 0);
        wait_done(n);
        check("hs_second_done", n, (LAT + 1) + LAT - 120);
        step();

        // Monitor clock stuck high.
        mon_run   = 1'b0;
        mon_stuck = 1'b1;
        repeat (20) step();
        run_req(1'b0, "stuck", 1'b0, 1'b0);

        // Abort during MEASURE.
        mon_run     = 1'b1;
        seen_done   = 1'b0;
        req_sel_i   = 1'b1;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        check("abort_sel_set", sel_o, 1);
        repeat (50) begin
            if (done_o === 1'b1) seen_done = 1'b1;
            step();
        end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("abort_sel", sel_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_ready", req_ready_o, 1);
        check("abort_done", done_o, 0);
        repeat (120) begin
            if (done_o === 1'b1) seen_done = 1'b1;
            step();
        end
        check("abort_no_done_pulse", seen_done, 0);
        run_req(1'b1, "post_abort", 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
